// File: rtl/taxi_eth_rx_drop_fifo.sv
// Store-and-forward RX frame FIFO for the 10G MAC receive path.
// Whole frames are buffered and published to the reader only once tlast
// arrives clean. Bad or overflowing frames are rolled back atomically.
// The MAC is never backpressured.
module taxi_eth_rx_drop_fifo #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = DATA_W / 8,
  parameter int USER_W = 1,
  parameter int DEPTH  = 512
) (
  input  logic                      rx_clk,
  input  logic                      rx_rst_n,
  input  logic [DATA_W-1:0]         s_axis_rx_tdata,
  input  logic [KEEP_W-1:0]         s_axis_rx_tkeep,
  input  logic                      s_axis_rx_tvalid,
  output logic                      s_axis_rx_tready,
  input  logic                      s_axis_rx_tlast,
  input  logic [USER_W-1:0]         s_axis_rx_tuser,
  output logic [DATA_W-1:0]         m_axis_rx_tdata,
  output logic [KEEP_W-1:0]         m_axis_rx_tkeep,
  output logic                      m_axis_rx_tvalid,
  input  logic                      m_axis_rx_tready,
  output logic                      m_axis_rx_tlast,
  output logic                      stat_frame_good,
  output logic                      stat_drop_bad,
  output logic                      stat_drop_full,
  output logic [$clog2(DEPTH):0]    fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int MW = DATA_W + KEEP_W + 1;  // {tlast, tkeep, tdata}

  typedef enum logic [1:0] {WR_IDLE, WR_ACTIVE, WR_DROP} wr_state_e;

  logic [MW-1:0] mem [DEPTH];
  logic [MW-1:0] ram_dout;

  wr_state_e     wr_state_q, wr_state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] wr_commit_q, wr_commit_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;        // advances on output handshake
  logic [PW-1:0] fetch_ptr_q, fetch_ptr_d;  // advances on RAM read
  logic          s1_valid_q, s1_valid_d;
  logic          out_valid_q, out_valid_d;
  logic [MW-1:0] out_word_q, out_word_d;
  logic          tready_q, tready_d;
  logic          stat_good_q, stat_good_d;
  logic          stat_bad_q, stat_bad_d;
  logic          stat_full_q, stat_full_d;

  logic beat, full, mem_we;
  logic out_ready, s1_ready, rd_en;

  assign beat = s_axis_rx_tvalid & tready_q;
  // Occupancy counts against the handshake pointer, so beats already
  // prefetched into the read pipeline still hold their slot.
  assign full = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);

  // Write FSM: store beats, then commit or roll back on the tlast beat.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    wr_state_d  = wr_state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    mem_we      = 1'b0;
    stat_good_d = 1'b0;
    stat_bad_d  = 1'b0;
    stat_full_d = 1'b0;
    tready_d    = 1'b1;
    if (beat) begin
      if (wr_state_q == WR_DROP || full) begin
        // Overflow dominates the bad flag; discard until tlast.
        if (s_axis_rx_tlast) begin
          wr_ptr_d    = wr_commit_q;
          stat_full_d = 1'b1;
          wr_state_d  = WR_IDLE;
        end else begin
          wr_state_d  = WR_DROP;
        end
      end else begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PW'(1);
        if (s_axis_rx_tlast) begin
          wr_state_d = WR_IDLE;
          if (s_axis_rx_tuser[0]) begin
            wr_ptr_d   = wr_commit_q;
            stat_bad_d = 1'b1;
          end else begin
            wr_commit_d = wr_ptr_q + PW'(1);
            stat_good_d = 1'b1;
          end
        end else begin
          wr_state_d = WR_ACTIVE;
        end
      end
    end
  end

  // Read pipeline: RAM read register feeding the AXIS output register.
  always_comb begin
    out_ready   = !out_valid_q || m_axis_rx_tready;
    s1_ready    = !s1_valid_q || out_ready;
    rd_en       = (fetch_ptr_q != wr_commit_q) && s1_ready;
    fetch_ptr_d = fetch_ptr_q + PW'(rd_en);
    rd_ptr_d    = rd_ptr_q + PW'(out_valid_q && m_axis_rx_tready);
    s1_valid_d  = rd_en || (s1_valid_q && !out_ready);
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    if (out_ready) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) out_word_d = ram_dout;
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge rx_clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (!rx_rst_n) begin
      wr_state_q  <= WR_IDLE;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      rd_ptr_q    <= '0;
      fetch_ptr_q <= '0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      tready_q    <= 1'b0;
      stat_good_q <= 1'b0;
      stat_bad_q  <= 1'b0;
      stat_full_q <= 1'b0;
    end else begin
      wr_state_q  <= wr_state_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q    <= rd_ptr_d;
      fetch_ptr_q <= fetch_ptr_d;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      tready_q    <= tready_d;
      stat_good_q <= stat_good_d;
      stat_bad_q  <= stat_bad_d;
      stat_full_q <= stat_full_d;
    end
  end

  // Frame storage with registered read port.
  always_ff @(posedge rx_clk) begin
    // NOTE: the array and its read register are not reset; validity is tracked by the pointers and s1_valid_q, which keeps this mappable to block RAM.
    if (mem_we) mem[wr_ptr_q[AW-1:0]] <= {s_axis_rx_tlast, s_axis_rx_tkeep, s_axis_rx_tdata};
    if (rd_en) ram_dout <= mem[fetch_ptr_q[AW-1:0]];
  end

  assign s_axis_rx_tready = tready_q;
  assign m_axis_rx_tvalid = out_valid_q;
  assign m_axis_rx_tdata  = out_word_q[DATA_W-1:0];
  assign m_axis_rx_tkeep  = out_word_q[DATA_W +: KEEP_W];
  assign m_axis_rx_tlast  = out_word_q[MW-1];
  assign stat_frame_good  = stat_good_q;
  assign stat_drop_bad    = stat_bad_q;
  assign stat_drop_full   = stat_full_q;
  assign fifo_level       = wr_commit_q - rd_ptr_q;

endmodule

// File: tb/tb_taxi_eth_rx_drop_fifo.sv
// Scoreboard bench for taxi_eth_rx_drop_fifo (DEPTH=16 so overflow is reachable).
module tb_taxi_eth_rx_drop_fifo;

  localparam int DATA_W = 64;
  localparam int KEEP_W = 8;
  localparam int USER_W = 1;
  localparam int DEPTH  = 16;
  localparam int PW     = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
  } beat_t;

  typedef enum int {ST_GOOD = 0, ST_BAD = 1, ST_FULL = 2} stat_e;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] s_tdata;
  logic [KEEP_W-1:0] s_tkeep;
  logic              s_tvalid;
  logic              s_tready;
  logic              s_tlast;
  logic [USER_W-1:0] s_tuser;
  logic [DATA_W-1:0] m_tdata;
  logic [KEEP_W-1:0] m_tkeep;
  logic              m_tvalid;
  logic              m_tready;
  logic              m_tlast;
  logic              stat_frame_good, stat_drop_bad, stat_drop_full;
  logic [PW-1:0]     fifo_level;

  logic rdy_rand = 1'b0;
  logic rdy_dir  = 1'b1;
  logic rdy_bit  = 1'b0;
  assign m_tready = rdy_rand ? rdy_bit : rdy_dir;

  always #5 clk = ~clk;

  taxi_eth_rx_drop_fifo #(
    .DATA_W(DATA_W), .KEEP_W(KEEP_W), .USER_W(USER_W), .DEPTH(DEPTH)
  ) dut (
    .rx_clk(clk), .rx_rst_n(rst_n),
    .s_axis_rx_tdata(s_tdata), .s_axis_rx_tkeep(s_tkeep),
    .s_axis_rx_tvalid(s_tvalid), .s_axis_rx_tready(s_tready),
    .s_axis_rx_tlast(s_tlast), .s_axis_rx_tuser(s_tuser),
    .m_axis_rx_tdata(m_tdata), .m_axis_rx_tkeep(m_tkeep),
    .m_axis_rx_tvalid(m_tvalid), .m_axis_rx_tready(m_tready),
    .m_axis_rx_tlast(m_tlast),
    .stat_frame_good(stat_frame_good), .stat_drop_bad(stat_drop_bad),
    .stat_drop_full(stat_drop_full), .fifo_level(fifo_level)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  beat_t exp_q[$];
  stat_e stat_q[$];
  beat_t first_beat;
  int    committed = 0;  // good beats issued
  int    popped    = 0;  // beats handshaken out
  int    cnt_good = 0, cnt_bad = 0, cnt_full = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Random consumer readiness, updated just after each rising edge.
  always @(posedge clk) begin
    #1 rdy_bit = 1'($urandom_range(0, 1));
  end

  // Output monitor: scoreboard pop, AXIS stability, sink always ready.
  logic  prev_stall = 1'b0;
  beat_t prev_beat;
  logic  prev_rst_n = 1'b0;
  always @(negedge clk) begin : out_mon
    beat_t got, e;
    got = '{data: m_tdata, keep: m_tkeep, last: m_tlast};
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_rst_n) check("s_tready_high", s_tready, 1'b1);
      if (prev_stall) begin
        check("axis_valid_held", m_tvalid, 1'b1);
        check("axis_word_held", got, prev_beat);
      end
      if (m_tvalid && m_tready) begin
        popped++;
        if (exp_q.size() == 0) begin
          check("beat_unexpected", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", got, e);
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = got;
    end
    prev_rst_n = rst_n;
  end

  // Statistics monitor: each pulse matched against the expected frame outcome.
  always @(negedge clk) begin : stat_mon
    logic [2:0] got;
    stat_e      e;
    got = {stat_drop_full, stat_drop_bad, stat_frame_good};
    if (rst_n && got != 3'b000) begin
      cnt_good += int'(stat_frame_good);
      cnt_bad  += int'(stat_drop_bad);
      cnt_full += int'(stat_drop_full);
      if (stat_q.size() == 0) begin
        check("stat_unexpected", got, 3'b000);
      end else begin
        e = stat_q.pop_front();
        check("stat_kind", got, 128'(1) << int'(e));
      end
    end
  end

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one frame back-to-back; the caller states the expected outcome.
  task automatic send_frame(input int len, input bit bad, input stat_e exp_stat);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data   = {$urandom, $urandom};
      b.keep   = 8'($urandom);
      b.last   = (i == len - 1);
      s_tdata  = b.data;
      s_tkeep  = b.keep;
      s_tlast  = b.last;
      s_tuser  = b.last ? 1'(bad) : 1'($urandom);
      s_tvalid = 1'b1;
      if (exp_stat == ST_GOOD) exp_q.push_back(b);
      if (i == 0) first_beat = b;
      @(posedge clk);
      #1;
    end
    stat_q.push_back(exp_stat);
    if (exp_stat == ST_GOOD) committed += len;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || fifo_level != 0 || m_tvalid) && k < 3000) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(name, k < 3000, 1'b1);
    idle(3);
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int g0, b0, f0, p0;
    int eg, eb, ef;
    int len, k;
    bit bad;
    rst_n = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
    s_tdata = '0; s_tkeep = '0; s_tuser = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", m_tvalid, 1'b0);
    check("rst_level", fifo_level, 0);
    check("rst_s_tready", s_tready, 1'b0);
    check("rst_stats", {stat_frame_good, stat_drop_bad, stat_drop_full}, 3'b000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_s_tready", s_tready, 1'b1);

    // 1: single 8-beat good frame, latency of two edges after commit
    rdy_dir = 1'b1;
    g0 = cnt_good;
    send_frame(8, 1'b0, ST_GOOD);
    s_tvalid = 1'b0;
    check("t1_valid_n0", m_tvalid, 1'b0);
    check("t1_good_pulse", stat_frame_good, 1'b1);
    check("t1_level_commit", fifo_level, 8);
    @(posedge clk); #1;
    check("t1_valid_n1", m_tvalid, 1'b0);
    check("t1_pulse_width", stat_frame_good, 1'b0);
    @(posedge clk); #1;
    check("t1_valid_n2", m_tvalid, 1'b1);
    check("t1_first_beat", {m_tdata, m_tkeep, m_tlast}, first_beat);
    drain("t1_drain");
    check("t1_good_cnt", cnt_good - g0, 1);
    check("t1_level_end", fifo_level, 0);

    // 2: good / bad / good back-to-back
    g0 = cnt_good; b0 = cnt_bad;
    send_frame(4, 1'b0, ST_GOOD);
    send_frame(6, 1'b1, ST_BAD);
    send_frame(3, 1'b0, ST_GOOD);
    idle(1);
    drain("t2_drain");
    check("t2_good_cnt", cnt_good - g0, 2);
    check("t2_bad_cnt", cnt_bad - b0, 1);

    // 3: consumer stalled, second frame overflows
    rdy_dir = 1'b0;
    f0 = cnt_full;
    send_frame(10, 1'b0, ST_GOOD);
    send_frame(10, 1'b0, ST_FULL);
    idle(4);
    check("t3_level", fifo_level, 10);
    check("t3_full_cnt", cnt_full - f0, 1);
    check("t3_head_valid", m_tvalid, 1'b1);
    p0 = popped;
    rdy_dir = 1'b1;
    drain("t3_drain");
    check("t3_beats_out", popped - p0, 10);

    // 4: frame longer than the FIFO into an empty FIFO
    f0 = cnt_full; p0 = popped;
    send_frame(20, 1'b0, ST_FULL);
    idle(4);
    check("t4_level", fifo_level, 0);
    check("t4_no_output", m_tvalid, 1'b0);
    check("t4_full_cnt", cnt_full - f0, 1);
    send_frame(2, 1'b0, ST_GOOD);
    idle(1);
    drain("t4_drain");
    check("t4_beats_out", popped - p0, 2);

    // 5: random frames, random consumer readiness
    g0 = cnt_good; b0 = cnt_bad; f0 = cnt_full;
    eg = 0; eb = 0; ef = 0;
    rdy_rand = 1'b1;
    for (int n = 0; n < 200; n++) begin
      len = $urandom_range(1, 64);
      bad = ($urandom_range(0, 9) == 0);
      if (len > DEPTH) begin
        send_frame(len, bad, ST_FULL);
        ef++;
      end else begin
        // Start only when the frame is guaranteed to fit.
        s_tvalid = 1'b0;
        k = 0;
        while ((committed - popped + len > DEPTH) && k < 2000) begin
          @(posedge clk); #1;
          k++;
        end
        if (k >= 2000) check("t5_space_timeout", 1'b0, 1'b1);
        if (bad) begin
          send_frame(len, 1'b1, ST_BAD);
          eb++;
        end else begin
          send_frame(len, 1'b0, ST_GOOD);
          eg++;
        end
      end
      idle($urandom_range(0, 3));
    end
    idle(1);
    rdy_rand = 1'b0;
    rdy_dir  = 1'b1;
    drain("t5_drain");
    check("t5_good_cnt", cnt_good - g0, eg);
    check("t5_bad_cnt", cnt_bad - b0, eb);
    check("t5_full_cnt", cnt_full - f0, ef);

    // 6: reset mid-frame with three frames stored
    rdy_dir = 1'b0;
    send_frame(3, 1'b0, ST_GOOD);
    send_frame(4, 1'b0, ST_GOOD);
    send_frame(2, 1'b0, ST_GOOD);
    for (int i = 0; i < 3; i++) begin
      s_tdata = {$urandom, $urandom}; s_tkeep = 8'hff;
      s_tlast = 1'b0; s_tuser = '0; s_tvalid = 1'b1;
      @(posedge clk); #1;
    end
    check("t6_level_before", fifo_level, 9);
    rst_n = 1'b0;
    s_tvalid = 1'b0;
    @(posedge clk); #1;
    check("t6_rst_valid", m_tvalid, 1'b0);
    check("t6_rst_level", fifo_level, 0);
    check("t6_rst_stats", {stat_frame_good, stat_drop_bad, stat_drop_full}, 3'b000);
    check("t6_rst_tready", s_tready, 1'b0);
    exp_q.delete();
    committed = popped;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t6_tready_back", s_tready, 1'b1);
    p0 = popped;
    rdy_dir = 1'b1;
    send_frame(5, 1'b0, ST_GOOD);
    idle(1);
    drain("t6_drain");
    check("t6_beats_out", popped - p0, 5);

    idle(5);
    check("sb_beats_left", exp_q.size(), 0);
    check("sb_stats_left", stat_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
